// File: rtl/cnt169_pkg.sv
// Shared definitions for the SN74169 counter driver: command op-codes,
// controller states and the counting-direction polarity on U_DB.
package cnt169_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_SEEK    = 2'b01,
    OP_STEP_UP = 2'b10,
    OP_STEP_DN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CHECK
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/cnt169_plan.sv
// Combinational command planner: turns an op, its argument and the current
// counter value into direction, step count, expected result and wrap flag.
module cnt169_plan
  import cnt169_pkg::*;
(
  input  logic [1:0] OP,
  input  logic [3:0] ARG,
  input  logic [3:0] Q0,
  output logic       DIR,
  output logic [3:0] N,
  output logic [3:0] EXP,
  output logic       WRAP_NEXT
);

  logic [3:0] w_dist;
  logic [4:0] w_up_sum;

  assign w_dist   = ARG - Q0;
  assign w_up_sum = {1'b0, Q0} + {1'b0, N};

  always_comb begin
    DIR = DIR_UP;
    N   = '0;
    EXP = ARG;
    unique case (op_e'(OP))
      OP_LOAD: begin
        N = '0;
      end
      OP_STEP_UP: begin
        N   = ARG;
        EXP = Q0 + ARG;
      end
      OP_STEP_DN: begin
        DIR = DIR_DN;
        N   = ARG;
        EXP = Q0 - ARG;
      end
      OP_SEEK: begin
        // Shortest path round the ring; a distance of exactly 8 goes up.
        if (w_dist == 4'd0) begin
          N = '0;
        end else if (w_dist <= 4'd8) begin
          N = w_dist;
        end else begin
          DIR = DIR_DN;
          N   = 4'd0 - w_dist;
        end
      end
    endcase
  end

  // With N = 0 neither branch can flag a wrap, so LOAD needs no special case.
  assign WRAP_NEXT = (DIR == DIR_UP) ? w_up_sum[4] : (N > Q0);

endmodule

// File: rtl/cnt169_driver.sv
// Command-driven controller for an SN74169-style 4-bit up/down counter:
// issues load/count pulses on the counter pins and verifies Q afterwards.
module cnt169_driver
  import cnt169_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [3:0] CMD_ARG,
  input  logic [3:0] Q_IN,
  output logic [3:0] A,
  output logic       LOADB,
  output logic       ENPB,
  output logic       ENTB,
  output logic       U_DB,
  output logic       DONE,
  output logic       ERR,
  output logic       WRAP
);

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_steps;
  logic [3:0] r_exp;
  logic       r_wrap_next;
  logic [3:0] r_a;
  logic       r_loadb;
  logic       r_enpb;
  logic       r_entb;
  logic       r_udb;
  logic       r_done;
  logic       r_err;
  logic       r_wrap;

  logic       w_accept;
  logic       w_dir;
  logic [3:0] w_n;
  logic [3:0] w_exp;
  logic       w_wrap_next;

  assign CMD_READY = (r_state == ST_IDLE);
  assign w_accept  = CMD_VALID && CMD_READY;

  cnt169_plan u_plan (
    .OP        (CMD_OP),
    .ARG       (CMD_ARG),
    .Q0        (Q_IN),
    .DIR       (w_dir),
    .N         (w_n),
    .EXP       (w_exp),
    .WRAP_NEXT (w_wrap_next)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (op_e'(CMD_OP) == OP_LOAD) w_state_next = ST_LOAD;
          else if (w_n != 4'd0)         w_state_next = ST_RUN;
          else                          w_state_next = ST_CHECK;
        end
      end
      ST_LOAD:  w_state_next = ST_CHECK;
      ST_RUN:   if (r_steps == 4'd1) w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = ST_IDLE;
    endcase
  end

  // Pin registers are loaded from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_steps     <= '0;
      r_exp       <= '0;
      r_wrap_next <= 1'b0;
      r_a         <= '0;
      r_loadb     <= 1'b1;
      r_enpb      <= 1'b1;
      r_entb      <= 1'b1;
      r_udb       <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_steps     <= w_n;
        r_exp       <= w_exp;
        r_wrap_next <= w_wrap_next;
      end else if (r_state == ST_RUN) begin
        r_steps <= r_steps - 4'd1;
      end
      r_loadb <= (w_state_next != ST_LOAD);
      r_enpb  <= (w_state_next != ST_RUN);
      r_entb  <= (w_state_next != ST_RUN);
      if (w_accept && w_state_next == ST_LOAD) r_a   <= CMD_ARG;
      if (w_accept && w_state_next == ST_RUN)  r_udb <= w_dir;
      r_done <= (r_state == ST_CHECK);
      if (r_state == ST_CHECK) begin
        r_err  <= (Q_IN != r_exp);
        r_wrap <= r_wrap_next;
      end
    end
  end

  assign A     = r_a;
  assign LOADB = r_loadb;
  assign ENPB  = r_enpb;
  assign ENTB  = r_entb;
  assign U_DB  = r_udb;
  assign DONE  = r_done;
  assign ERR   = r_err;
  assign WRAP  = r_wrap;

endmodule

// File: tb/tb_cnt169_driver.sv
// Scoreboard bench for cnt169_driver with a behavioural SN74169 counter model.
module tb_cnt169_driver;

  logic       CLK;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [3:0] CMD_ARG;
  logic [3:0] Q_IN;
  logic [3:0] A;
  logic       LOADB, ENPB, ENTB, U_DB, DONE, ERR, WRAP;

  logic [3:0] q;
  bit         freeze;
  bit         chk_rst;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    bit         up;
    int         en;
    int         ld;
    bit         err;
    bit         wrap;
    int         lat;
    longint     t_done;
  } exp_t;

  exp_t sb[$];

  cnt169_driver dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_ARG   (CMD_ARG),
    .Q_IN      (Q_IN),
    .A         (A),
    .LOADB     (LOADB),
    .ENPB      (ENPB),
    .ENTB      (ENTB),
    .U_DB      (U_DB),
    .DONE      (DONE),
    .ERR       (ERR),
    .WRAP      (WRAP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External counter: load wins over count; freeze models a stuck enable path.
  initial q = 4'd0;
  always @(posedge CLK) begin
    if (!LOADB)                          q <= A;
    else if (!ENPB && !ENTB && !freeze)  q <= U_DB ? q + 4'd1 : q - 4'd1;
  end
  assign Q_IN = q;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: outcome of a command from the counter value seen at accept.
  function automatic exp_t model(input int op, input int arg, input int q0,
                                 input bit frz, input longint t_acc);
    exp_t e;
    int d, n, tgt, fin;
    bit up;
    up = 1; n = 0; tgt = arg;
    case (op)
      2: begin up = 1; n = arg; tgt = (q0 + arg) % 16; end
      3: begin up = 0; n = arg; tgt = (q0 - arg + 16) % 16; end
      1: begin
        d = (arg - q0 + 16) % 16;
        if (d == 0)      n = 0;
        else if (d <= 8) begin up = 1; n = d; end
        else             begin up = 0; n = 16 - d; end
      end
      default: n = 0;
    endcase
    e.a    = 4'(arg);
    e.up   = up;
    e.en   = n;
    e.ld   = (op == 0) ? 1 : 0;
    e.wrap = (op == 0) ? 1'b0 : (up ? (q0 + n > 15) : (n > q0));
    fin    = (op == 0) ? arg : (frz ? q0 : tgt);
    e.err  = (fin != tgt);
    e.lat  = (op == 0) ? 3 : ((n > 0) ? n + 2 : 2);
    e.t_done = t_acc + longint'(e.lat - 1) * 10 + 5;
    return e;
  endfunction

  // Monitor: accumulates pin activity and pops the scoreboard on each DONE.
  initial begin : monitor
    int n_en, n_ld, bad;
    exp_t e;
    n_en = 0; n_ld = 0; bad = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        n_en = 0; n_ld = 0; bad = 0;
      end else begin
        if (chk_rst)
          chk("reset_outputs",
              int'({LOADB, ENPB, ENTB, U_DB, A, DONE, ERR, WRAP, CMD_READY}),
              int'(12'b1111_0000_0001));
        if (!ENPB || !ENTB) begin
          n_en++;
          if (ENPB != ENTB || sb.size() == 0 || U_DB != sb[0].up) bad++;
        end
        if (!LOADB) begin
          n_ld++;
          if (sb.size() == 0 || A != sb[0].a) bad++;
        end
        if (DONE) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("err",        int'(ERR),  int'(e.err));
            chk("wrap",       int'(WRAP), int'(e.wrap));
            chk("done_time",  int'($time), int'(e.t_done));
            chk("en_cycles",  n_en, e.en);
            chk("load_cycles", n_ld, e.ld);
            chk("pin_values_bad", bad, 0);
          end
          n_en = 0; n_ld = 0; bad = 0;
        end
      end
    end
  end

  task automatic issue(input int op, input int arg, input bit hold,
                       output longint t_acc, output int lat);
    bit   got;
    exp_t e;
    got = 0; t_acc = 0; lat = 0;
    CMD_OP = 2'(op); CMD_ARG = 4'(arg); CMD_VALID = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge CLK);
      if (CMD_READY && !RST) begin
        got   = 1;
        t_acc = longint'($time);
        e     = model(op, arg, int'(q), freeze, t_acc);
        lat   = e.lat;
        sb.push_back(e);
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    #1;
    if (!hold) CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge CLK);
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    #1;
  endtask

  task automatic run(input int op, input int arg);
    longint t;
    int l;
    issue(op, arg, 0, t, l);
    wait_idle();
  endtask

  initial begin : stim
    longint t1, t2;
    int l1, l2;
    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_ARG = '0;
    freeze = 0; chk_rst = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0; chk_rst = 1;
    @(negedge CLK); #1 chk_rst = 0;

    run(0, 3);   run(0, 10);           // LOAD 0xA from 3
    run(0, 14);  run(2, 3);            // STEP_UP 3 from 14 wraps to 1
    run(0, 2);   run(1, 10);           // SEEK D=8: up 8
    run(0, 2);   run(1, 11);           // SEEK D=9: down 7 with wrap
    run(1, 11);                        // SEEK to current value
    run(0, 5);
    freeze = 1; run(3, 4); freeze = 0; // stuck counter -> ERR

    run(0, 3);                         // reset in the middle of STEP_UP 10
    issue(2, 10, 0, t1, l1);
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1; sb.delete();
    @(posedge CLK);
    #1 RST = 1'b0; chk_rst = 1;
    @(negedge CLK); #1 chk_rst = 0;
    repeat (20) @(posedge CLK);
    #1 chk("ready_after_reset", int'(CMD_READY), 1);

    run(0, 4);                         // back-to-back with CMD_VALID held
    issue(2, 5, 1, t1, l1);
    issue(1, 0, 0, t2, l2);
    chk("b2b_accept_gap", int'(t2 - t1), l1 * 10);
    wait_idle();

    for (int i = 0; i < 50; i++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation_time_exceeded required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cnt169_driver.md
# cnt169_driver

Command-driven controller for an external or on-chip SN74169-style 4-bit up/down counter. It drives the counter's active-low control pins (LOADB, ENPB, ENTB), U_DB and the A inputs. It accepts load, seek and step commands over a valid/ready handshake and then reads back the counter's Q to confirm the result. It sits between a host sequencer and the counter.

## Interface
Parameters: none; widths are fixed to the 4-bit counter.

Ports:
- CLK  in  1  rising-edge clock; shared with the driven counter
- RST  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  high when state is IDLE
- CMD_OP  in  2  00 LOAD, 01 SEEK, 10 STEP_UP, 11 STEP_DN
- CMD_ARG  in  4  load value, seek target, or step count
- Q_IN  in  4  counter Q readback
- A  out  4  counter parallel-load data
- LOADB  out  1  active-low load strobe to counter
- ENPB  out  1  active-low count enable P
- ENTB  out  1  active-low count enable T
- U_DB  out  1  1 = count up, 0 = count down
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  readback mismatch on the last command; valid with DONE and held until the next DONE
- WRAP  out  1  last command crossed the 15/0 boundary; valid with DONE and held until the next DONE

## Operation
- States: IDLE, LOAD, RUN, CHECK.
- A command is accepted on a rising edge where CMD_VALID and CMD_READY are both high. At acceptance the block latches Q0 = Q_IN and computes:
  - DIR: direction of counting
  - N: step count, 0..15
  - EXP: expected final counter value
  - WRAP_NEXT: whether the command crosses the 15/0 boundary
- Per-op plan (all arithmetic mod 16):
  - LOAD: EXP = ARG, WRAP_NEXT = 0. Next state is LOAD.
  - STEP_UP: DIR = up, N = ARG, EXP = Q0 + ARG, WRAP_NEXT = (Q0 + ARG > 15).
  - STEP_DN: DIR = down, N = ARG, EXP = Q0 - ARG, WRAP_NEXT = (ARG > Q0).
  - SEEK: D = (ARG - Q0) mod 16. If D = 0, N = 0. If 1 ≤ D ≤ 8, count up with N = D. If D ≥ 9, count down with N = 16 - D. EXP = ARG. WRAP_NEXT is computed as for a STEP_UP or STEP_DN of N.
- Next state after accept: LOAD for the LOAD op. Otherwise RUN if N > 0, or CHECK if N = 0.
- LOAD state (1 cycle): LOADB = 0, A = ARG. Next state is CHECK.
- RUN state (N cycles): ENPB = ENTB = 0, U_DB = DIR, LOADB = 1. An internal down-counter of remaining steps moves to CHECK after the Nth cycle.
- CHECK state (1 cycle): compares Q_IN to EXP. On the edge leaving CHECK the block registers DONE = 1, ERR = (Q_IN != EXP) and WRAP = WRAP_NEXT, and returns to IDLE.
- Outside LOAD and RUN, the control outputs are inactive: LOADB = ENPB = ENTB = 1. U_DB holds its last value. A holds its last value.
- CMD_VALID and CMD_ARG are ignored while not in IDLE. A new command can be accepted in the same cycle that DONE is high.

## Timing
- All outputs are registered except CMD_READY, which decodes the state directly.
- Counter semantics: the counter applies LOADB, ENPB, ENTB and U_DB at the edge that ends the cycle in which they are driven. Q_IN in CHECK therefore reflects the final step.
- Latency, counted in cycles after the accept edge:
  - LOAD: LOAD in cycle 1, CHECK in cycle 2, DONE in cycle 3.
  - Steps with N > 0: RUN in cycles 1..N, CHECK in cycle N+1, DONE in cycle N+2.
  - N = 0: CHECK in cycle 1, DONE in cycle 2, with no enable ever asserted.
- Reset, applied at any edge including mid-RUN:
  - state → IDLE
  - LOADB = ENPB = ENTB = U_DB = 1
  - A = 0
  - DONE = ERR = WRAP = 0
  - no DONE is issued for the aborted command
  - CMD_READY is 1 from the cycle after the reset edge; it is 0 only if RST is held and the design chooses to gate it (it must not: CMD_READY = (state == IDLE) regardless of RST).
- Q_IN is sampled only at accept and in CHECK. Changes at other times are ignored.

## Structure
- Shared package cnt169_pkg: op-code constants (OP_LOAD, OP_SEEK, OP_STEP_UP, OP_STEP_DN) and the state encoding.
- One combinational sub-module, cnt169_plan: inputs OP, ARG and Q0; outputs DIR, N, EXP and WRAP_NEXT. It is instantiated once, at acceptance.
- The top level holds the FSM, the remaining-step counter and the output registers.

## Test plan
- Reset mid-RUN of STEP_UP 10: ENPB and ENTB return to 1 the next cycle, DONE never pulses, and CMD_READY = 1 afterwards.
- LOAD 0xA with the counter model at 3: LOADB = 0 for exactly 1 cycle with A = 0xA. DONE arrives 3 cycles after accept with ERR = 0 and WRAP = 0.
- Counter at 14, STEP_UP 3: ENPB and ENTB are low for 3 cycles with U_DB = 1. Counter ends at 1, and DONE is accompanied by WRAP = 1 and ERR = 0.
- SEEK ties and zero distance:
  - counter at 2, SEEK 10 (D = 8): 8 up-steps, no wrap
  - counter at 2, SEEK 11 (D = 9): 7 down-steps with WRAP = 1
  - SEEK to the current value: DONE 2 cycles after accept with no enables asserted
- Counter model frozen so it ignores ENPB and ENTB, then STEP_DN 4 from 5: DONE with ERR = 1 (EXP = 1, Q_IN = 5).
- Back-to-back commands with CMD_VALID held high: the second command is accepted in the DONE cycle of the first, and nothing is accepted while busy.
